// File: rtl/data_plus_ctrl.sv
// Multicycle MIPS-subset processor with a built-in program ROM and data RAM.
// Runs the program from reset until HALT, then holds the result on out and
// raises done.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   out   : low 16 bits of reg[OUT_REG], captured on the HALT-entry edge
//   done  : high once HALT has been decoded
module data_plus_ctrl #(
    parameter int unsigned PROG_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64,
    parameter int unsigned OUT_REG    = 3,
    // Program image, word 0 in the low 32 bits; unused words are 0 (sll NOP)
    parameter logic [PROG_WORDS*32-1:0] ROM_IMAGE = {
        {((PROG_WORDS - 9) * 32){1'b0}},
        32'hFC00_0000,   // 8: halt
        32'h8C03_0000,   // 7: lw   $3,0($0)
        32'hAC02_0000,   // 6: sw   $2,0($0)
        32'h0800_0002,   // 5: j    2
        32'h2021_FFFF,   // 4: addi $1,$1,-1
        32'h0041_1020,   // 3: add  $2,$2,$1
        32'h1020_0003,   // 2: beq  $1,$0,+3
        32'h2002_0000,   // 1: addi $2,$0,0
        32'h2001_000A    // 0: addi $1,$0,10
    }
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out,
    output logic        done
);

    localparam int unsigned PAW = $clog2(PROG_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);
    localparam logic [4:0]  OUT_IDX = 5'(OUT_REG);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [15:0] out_q, out_d;
    logic        done_q, done_d;

    logic [31:0] regs_q [32];
    logic [31:0] ram_q  [DMEM_WORDS];

    logic            rf_we_c;
    logic [4:0]      rf_waddr_c;
    logic [31:0]     rf_wdata_c;
    logic            ram_we_c;
    logic [DAW-1:0]  ram_idx_c;
    logic [PAW-1:0]  rom_idx_c;
    logic [31:0]     rom_word_c;
    logic [31:0]     alu_r_c;
    logic            r_valid_c;

    logic [5:0]  op_c, funct_c;
    logic [4:0]  rs_c, rt_c, rd_c;
    logic [31:0] simm_c;
    logic        unused_c;

    // Instruction fields
    assign op_c     = ir_q[31:26];
    assign rs_c     = ir_q[25:21];
    assign rt_c     = ir_q[20:16];
    assign rd_c     = ir_q[15:11];
    assign funct_c  = ir_q[5:0];
    assign simm_c   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign unused_c = ^ir_q[10:6];

    // Word-indexed ROM/RAM, wrapping on the low address bits
    assign rom_idx_c  = pc_q[PAW+1:2];
    assign rom_word_c = ROM_IMAGE[{rom_idx_c, 5'b0} +: 32];
    assign ram_idx_c  = alu_q[DAW+1:2];

    assign r_valid_c = (op_c == OP_RTYPE) &&
                       (funct_c inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});

    // R-type ALU
    always_comb begin
        alu_r_c = '0;
        case (funct_c)
            FN_ADD:  alu_r_c = a_q + b_q;
            FN_SUB:  alu_r_c = a_q - b_q;
            FN_AND:  alu_r_c = a_q & b_q;
            FN_OR:   alu_r_c = a_q | b_q;
            FN_SLT:  alu_r_c = {31'b0, ($signed(a_q) < $signed(b_q))};
            default: alu_r_c = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        out_d      = out_q;
        done_d     = done_q;
        rf_we_c    = 1'b0;
        rf_waddr_c = '0;
        rf_wdata_c = '0;
        ram_we_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = rom_word_c;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = regs_q[rs_c];
                b_d = regs_q[rt_c];
                if (op_c == OP_HALT) begin
                    out_d   = regs_q[OUT_IDX][15:0];
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else if (r_valid_c ||
                             (op_c inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J})) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_c)
                    OP_RTYPE: begin
                        alu_d   = alu_r_c;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + simm_c;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + simm_c;
                        state_d = S_MEM;
                    end
                    // pc_q already holds PC+4 of the branch/jump
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = pc_q + {simm_c[29:0], 2'b00};
                    end
                    OP_J: begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op_c == OP_SW) begin
                    ram_we_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    mdr_d   = ram_q[ram_idx_c];
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (op_c == OP_RTYPE) begin
                    rf_waddr_c = rd_c;
                    rf_wdata_c = alu_q;
                end else if (op_c == OP_LW) begin
                    rf_waddr_c = rt_c;
                    rf_wdata_c = mdr_q;
                end else begin
                    rf_waddr_c = rt_c;
                    rf_wdata_c = alu_q;
                end
                // $0 is hardwired to zero
                rf_we_c = (rf_waddr_c != 5'd0);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else if (rf_we_c) begin
            regs_q[rf_waddr_c] <= rf_wdata_c;
        end
    end

    // Data RAM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_q <= '{default: '0};
        end else if (ram_we_c) begin
            ram_q[ram_idx_c] <= b_q;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: tb/tb_data_plus_ctrl.sv
// Scoreboard bench for data_plus_ctrl: expected out/done values are queued per
// clock edge by the stimulus and compared by a negedge monitor. A second
// instance runs a tiny program that attempts to write $0.
module tb_data_plus_ctrl;

    typedef struct {
        logic [15:0] out;
        logic        done;
        int          edge_no;
        string       tag;
    } exp_t;

    localparam logic [64*32-1:0] ROM0 = {{(62 * 32){1'b0}},
                                         32'hFC00_0000,   // halt
                                         32'h2000_0005};  // addi $0,$0,5

    logic        clk;
    logic        reset;
    logic [15:0] out;
    logic        done;
    logic [15:0] out0;
    logic        done0;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    data_plus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .out   (out),
        .done  (done)
    );

    data_plus_ctrl #(
        .OUT_REG   (0),
        .ROM_IMAGE (ROM0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .out   (out0),
        .done  (done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] o, input logic d, input int e, input string tag);
        exp_t x;
        x.out     = o;
        x.done    = d;
        x.edge_no = e;
        x.tag     = tag;
        sb_q.push_back(x);
    endtask

    // Monitor: compares DUT outputs against the queued expectation each negedge
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t x;
            x = sb_q.pop_front();
            chk($sformatf("%s_out_e%0d", x.tag, x.edge_no), 32'(out), 32'(x.out));
            chk($sformatf("%s_done_e%0d", x.tag, x.edge_no), 32'(done), 32'(x.done));
        end
    end

    // Run n edges after reset release; done expected from done_edge onward
    task automatic run_edges(input int n, input int done_edge, input bit peeks, input string tag);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (e >= done_edge) push(16'h0037, 1'b1, e, tag);
            else                push(16'h0000, 1'b0, e, tag);
            if (peeks) begin
                if (e == 5) chk("dut0_done_before_halt", 32'(done0), 32'd0);
                if (e == 6) begin
                    chk("dut0_done_at_halt", 32'(done0), 32'd1);
                    chk("dut0_out_r0_zero", 32'(out0), 32'h0);
                    chk("dut0_reg0_zero", dut0.regs_q[0], 32'h0);
                end
                if (e == 11) begin
                    chk("beq_first_not_taken_pc", dut.pc_q, 32'h0000_000C);
                    chk("beq_first_back_to_fetch", 32'(dut.state_q), 32'd0);
                end
                if (e == 15) chk("wb_add_first_iter_r2", dut.regs_q[2], 32'd10);
                if (e == 151) chk("beq_final_taken_pc", dut.pc_q, 32'h0000_0018);
                if (e == 160) begin
                    chk("lw_result_r3", dut.regs_q[3], 32'd55);
                    chk("sum_r2", dut.regs_q[2], 32'd55);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;

        // Reset held for 5 cycles
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            push(16'h0000, 1'b0, i, "rst_hold");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full run plus 200 cycles of stable result
        run_edges(162 + 200, 162, 1'b1, "run1");
        chk("dut0_done_hold", 32'(done0), 32'd1);
        chk("dut0_out_hold", 32'(out0), 32'h0);

        // Asynchronous reset mid-clock while done is high
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_pc", dut.pc_q, 32'h0);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            push(16'h0000, 1'b0, i, "rst_async");
        end
        reset = 1'b1;

        // Abort a run at edge 50, then rerun to completion
        run_edges(50, 1000, 1'b0, "run2");
        #1;
        reset = 1'b0;
        #1;
        chk("abort_rst_done", 32'(done), 32'd0);
        chk("abort_rst_r2", dut.regs_q[2], 32'h0);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            push(16'h0000, 1'b0, i, "rst_abort");
        end
        reset = 1'b1;
        run_edges(170, 162, 1'b0, "run3");

        // Drain the scoreboard
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_plus_ctrl.md
Name: data_plus_ctrl

Overview:
- Small multicycle MIPS-subset processor: datapath, register file, FSM control, internal program ROM and data RAM in one block.
- Runs a built-in program from reset until a HALT instruction, then raises done and presents a 16-bit result on out.
- Sits under the board top level. reset arrives already debounced. out feeds a 4-digit hex display through a nibble mux; done gates the display update.

Parameters:
- PROG_WORDS, 64, instruction ROM depth in 32-bit words. PC wraps modulo this size.
- DMEM_WORDS, 64, data RAM depth in 32-bit words. Addresses wrap modulo this size.
- OUT_REG, 3, register-file index whose low 16 bits are captured into out at HALT.

Ports:
- clk: input, 1 bit. Single system clock; all state changes on its rising edge.
- reset: input, 1 bit. Asynchronous, active-low reset.
- out: output, 16 bits. Result register, captured at HALT.
- done: output, 1 bit. High once HALT has been decoded.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0, state=FETCH, all 32 registers=0, data RAM=0, out=16'h0000, done=0.
  - Asserting reset mid-run aborts immediately; the program restarts from PC 0 on release.
- Architecture:
  - 32x32-bit register file; $0 always reads 0 and writes to it are ignored.
  - PC is a byte address; each instruction advances it by 4.
  - ROM and RAM are indexed by address[7:2] and wrap.
- Encodings (standard MIPS fields):
  - R-type, opcode 0: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02; halt 0x3F.
  - Any other opcode/funct is a NOP: after DECODE, return to FETCH with PC+4.
- Arithmetic: 32-bit two's complement, overflow ignored (wraps). Immediates are sign-extended.
- Branch target = PC+4+(simm<<2). Jump target = {PC+4[31:28], addr26, 2'b00}.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: latch IR from ROM[PC]; PC <= PC+4.
  - DECODE: read rs/rt. halt goes to HALT, with out <= reg[OUT_REG][15:0] and done <= 1 on this same edge.
  - EXEC: ALU/address compute. beq: PC updated if taken, then FETCH. j: PC loaded, then FETCH.
  - MEM: sw writes RAM and goes to FETCH; lw reads RAM and goes to WB.
  - WB: write rd (R-type) or rt (addi, lw), then FETCH.
  - HALT: absorbing. No further register, RAM, PC, out or done changes until reset.
- Cycle counts in clock edges: R-type 4, addi 4, sw 4, lw 5, beq 3 (taken or not), j 3, halt 2 to reach HALT.
- out holds 0 while running and changes only on the HALT-entry edge.
- Built-in ROM program; all other ROM words are 0, which decodes as the R-type NOP sll:
  - 0: addi $1,$0,10
  - 1: addi $2,$0,0
  - 2: beq $1,$0,+3
  - 3: add $2,$2,$1
  - 4: addi $1,$1,-1
  - 5: j 2
  - 6: sw $2,0($0)
  - 7: lw $3,0($0)
  - 8: halt
- Expected result: $2=$3=55, out=16'h0037.
- Timing of the built-in program: 8 + 10x14 + 3 + 4 + 5 = 160 edges to retire lw. done rises on the 162nd rising edge after reset release.

Test Plan:
- Hold reset=0 for 5 cycles, toggling clk -> out=16'h0000, done=0 throughout.
- Release reset, run -> done=0 through edge 161; done=1 and out=16'h0037 after edge 162.
- After done, run 200 more cycles -> out=16'h0037, done=1, both stable with no glitches.
- Assert reset asynchronously (mid-clock) at edge 50 -> out=0 and done=0 immediately without waiting for a clock edge. Release -> done again after exactly 162 edges with out=16'h0037.
- Peek the register file at WB of instruction 3 in the first iteration -> $2=10. At the first beq -> not taken (3 edges). At the final beq with $1=0 -> taken to PC=0x18.
- Write-to-$0 check: substitute a ROM image (via hierarchical override) containing addi $0,$0,5 followed by halt, with OUT_REG=0 -> out=16'h0000.
